// File: rtl/rv32_pkg.sv
// Shared core types for the rv32 memory path.
package rv32;
  typedef logic [31:0] word;

  // Bus port arbiter states: owner is locked from REQ_x until its response.
  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} arb_state_t;

  // Fetches always read a full word.
  localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between fetch (I) and load/store (D).
// D wins by default; I is forced through after STARVE_LIMIT D grants.
// One transaction in flight; flush drops a stale fetch response.
module mem_port_arbiter
  import rv32::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       i_req,
  input  word        i_addr,
  output logic       i_gnt,
  output logic       i_rvalid,
  output word        i_rdata,
  output logic       i_err,
  input  logic       d_req,
  input  logic       d_we,
  input  word        d_addr,
  input  word        d_wdata,
  input  logic [3:0] d_be,
  output logic       d_gnt,
  output logic       d_rvalid,
  output word        d_rdata,
  output logic       d_err,
  output logic       bus_req,
  output logic       bus_we,
  output word        bus_addr,
  output word        bus_wdata,
  output logic [3:0] bus_be,
  input  logic       bus_gnt,
  input  logic       bus_rvalid,
  input  word        bus_rdata,
  input  logic       bus_err
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state, next_state;
  logic [3:0] starve_cnt;
  logic       discard;
  logic       sel_d;
  logic       own_d;

  // IDLE arbitration: D unless I has waited through LIMIT D grants.
  assign sel_d = d_req && (!i_req || (starve_cnt < LIMIT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, grants and response routing; everything held low in reset.
  always_comb begin
    next_state = state;
    bus_req    = 1'b0;
    own_d      = 1'b0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    case (state)
      IDLE: begin
        bus_req = i_req | d_req;
        own_d   = sel_d;
        if (bus_req) begin
          if (bus_gnt) begin
            next_state = sel_d ? WAIT_D : WAIT_I;
            d_gnt      = sel_d;
            i_gnt      = !sel_d;
          end else begin
            next_state = sel_d ? REQ_D : REQ_I;
          end
        end
      end
      REQ_I: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          i_gnt      = 1'b1;
          next_state = WAIT_I;
        end
      end
      REQ_D: begin
        bus_req = 1'b1;
        own_d   = 1'b1;
        if (bus_gnt) begin
          d_gnt      = 1'b1;
          next_state = WAIT_D;
        end
      end
      WAIT_I: begin
        // A cancelled fetch is consumed from the bus but never shown to fetch.
        if (bus_rvalid) begin
          i_rvalid   = !(discard || flush);
          next_state = IDLE;
        end
      end
      WAIT_D: begin
        if (bus_rvalid) begin
          d_rvalid   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (rst) begin
      bus_req  = 1'b0;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end
  end

  // Bus mux follows the selected (IDLE) or locked (REQ_x) owner.
  assign bus_we    = own_d & d_we;
  assign bus_addr  = own_d ? d_addr : i_addr;
  assign bus_wdata = own_d ? d_wdata : '0;
  assign bus_be    = own_d ? d_be : FETCH_BE;

  assign i_rdata = i_rvalid ? bus_rdata : '0;
  assign i_err   = i_rvalid & bus_err;
  assign d_rdata = d_rvalid ? bus_rdata : '0;
  assign d_err   = d_rvalid & bus_err;

  // Starvation counter: D grants while I waits, saturating at LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (i_gnt || (state == IDLE && !i_req))
      starve_cnt <= '0;
    else if (d_gnt && i_req && (starve_cnt < LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Discard flag: remembers a flush that hit the fetch currently in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      discard <= 1'b0;
    else if (state == WAIT_I && bus_rvalid)
      discard <= 1'b0;
    else if (flush && (state == REQ_I || state == WAIT_I || i_gnt))
      discard <= 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: transaction-level reference model plus response scoreboard.
module tb_mem_port_arbiter;
  import rv32::*;
  localparam int LIM = 4;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic i_req = 1'b0, i_gnt, i_rvalid, i_err;
  word  i_addr = '0, i_rdata;
  logic d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid, d_err;
  word  d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0] d_be = 4'h0, bus_be;
  logic bus_req, bus_we, bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  word  bus_addr, bus_wdata, bus_rdata = '0;

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  typedef struct { word data; logic err; } resp_t;
  resp_t iq[$], dq[$];

  // Reference model: one transaction at a time, who wins and what it carries.
  bit chk_en = 0;
  bit busy = 0, granted = 0, own_d = 0, kill = 0;
  int starve = 0;
  bit i_seen = 0, d_seen = 0, acc_seen = 0;
  int lat = -1;

  always @(negedge clk) if (chk_en) begin
    bit first;
    resp_t r;
    first = 0;
    if (!busy) begin
      if (!i_req) starve = 0;
      if (i_req || d_req) begin
        own_d = d_req && (!i_req || starve < LIM);
        busy = 1; granted = 0; kill = 0; first = 1;
      end else begin
        chk("idle_bus_req", bus_req, 0);
      end
    end
    if (busy && !granted) begin
      chk("req_bus_req", bus_req, 1);
      if (own_d) begin
        chk("d_bus_addr", bus_addr, d_addr);
        chk("d_bus_we", bus_we, d_we);
        chk("d_bus_be", bus_be, d_be);
        chk("d_bus_wdata", bus_wdata, d_wdata);
      end else begin
        chk("i_bus_addr", bus_addr, i_addr);
        chk("i_bus_we", bus_we, 0);
        chk("i_bus_be", bus_be, 4'hF);
      end
      chk("gnt", {i_gnt, d_gnt}, bus_gnt ? (own_d ? 2'b01 : 2'b10) : 2'b00);
      if (!own_d && flush && (!first || bus_gnt)) kill = 1;
      if (bus_gnt) begin
        granted = 1; acc_seen = 1;
        if (own_d) begin
          d_seen = 1;
          if (i_req && starve < LIM) starve++;
        end else begin
          i_seen = 1; starve = 0;
        end
      end
    end else if (busy) begin
      chk("wait_quiet", {bus_req, i_gnt, d_gnt}, 0);
      if (!own_d && flush) kill = 1;
      if (bus_rvalid) begin
        r.data = bus_rdata; r.err = bus_err;
        if (own_d) dq.push_back(r);
        else if (!kill) iq.push_back(r);
        busy = 0;
      end
    end
  end

  // Monitor: pops the expected response whenever a port presents rvalid.
  always @(negedge clk) if (chk_en) begin
    resp_t r;
    #2;
    if (i_rvalid) begin
      if (iq.size() == 0) begin
        total++;
        $display("FAIL i_rvalid_unexpected: got rvalid=1 expected no fetch response at %0t", $time);
      end else begin
        r = iq.pop_front();
        chk("i_rdata", i_rdata, r.data);
        chk("i_err", i_err, r.err);
      end
    end
    if (d_rvalid) begin
      if (dq.size() == 0) begin
        total++;
        $display("FAIL d_rvalid_unexpected: got rvalid=1 expected no data response at %0t", $time);
      end else begin
        r = dq.pop_front();
        chk("d_rdata", d_rdata, r.data);
        chk("d_err", d_err, r.err);
      end
    end
  end

  // One cycle of stimulus: requesters, flush, and a bus slave with 1..3 cycle latency.
  task automatic step(input int pi, input int pd, input int pf, input int pg);
    @(posedge clk); #1;
    if (i_seen) begin i_req = 0; i_seen = 0; end
    if (d_seen) begin d_req = 0; d_seen = 0; end
    if (!i_req && $urandom_range(99) < pi) begin
      i_req = 1; i_addr = $urandom() & 32'h7FFF_FFFC;
    end
    if (!d_req && $urandom_range(99) < pd) begin
      d_req = 1; d_addr = $urandom() | 32'h8000_0000; d_we = 1'($urandom_range(1));
      d_wdata = $urandom(); d_be = 4'($urandom_range(1, 15));
    end
    flush   = $urandom_range(99) < pf;
    bus_gnt = $urandom_range(99) < pg;
    bus_rvalid = 0; bus_err = 0;
    if (acc_seen) begin acc_seen = 0; lat = $urandom_range(0, 2); end
    if (lat == 0) begin
      bus_rvalid = 1; bus_rdata = $urandom(); bus_err = ($urandom_range(7) == 0); lat = -1;
    end else if (lat > 0) lat--;
  endtask

  initial begin
    // Outputs stay low under reset even with every input active.
    #2;
    i_req = 1; d_req = 1; bus_gnt = 1; bus_rvalid = 1; flush = 1;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
    i_req = 0; d_req = 0; bus_gnt = 0; bus_rvalid = 0; flush = 0;
    @(posedge clk); #1 rst = 0;
    chk_en = 1;

    repeat (1500) step(40, 40, 8, 60);
    repeat (400)  step(100, 100, 5, 100);   // saturated contention: D,D,D,D,I pattern
    repeat (1500) step(70, 60, 15, 40);
    repeat (60)   step(0, 0, 0, 100);       // drain held requests and responses
    @(negedge clk); #3;
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    chk("model_idle", busy, 0);
    chk_en = 0;

    // Directed: reset while waiting on a D response.
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h8000_0040; d_be = 4'hF; bus_gnt = 1; flush = 0;
    @(negedge clk);
    chk("dir_d_gnt", d_gnt, 1);
    @(posedge clk); #1;
    d_req = 0; bus_gnt = 0;
    #2;
    rst = 1; d_req = 1; bus_rvalid = 1; bus_rdata = 32'h1234_5678;
    #1;
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_d_rvalid", {d_rvalid, d_rdata}, 0);
    chk("midrst_gnt", d_gnt, 0);
    @(posedge clk); #1;
    rst = 0; bus_rvalid = 0; d_addr = 32'h8000_0080; bus_gnt = 1;
    @(negedge clk);
    chk("postrst_bus_req", bus_req, 1);
    chk("postrst_addr", bus_addr, 32'h8000_0080);
    chk("postrst_d_gnt", d_gnt, 1);
    @(posedge clk); #1;
    d_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("postrst_d_rvalid", d_rvalid, 1);
    chk("postrst_d_rdata", d_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1 bus_rvalid = 0;
    @(negedge clk);
    chk("postrst_idle", bus_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
